// File: rtl/seven_seg_scan_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_if
//   Bundle between the mode mux (stopwatch / clock / timer digit source) and
//   the seven-segment scanner.
//
//   Digit side (driven by the mode mux):
//     tenmin, onemin, tensec, onesec : BCD digits 3..0 (digit 3 leftmost)
//     lzb                            : blank digit 3 when its value is 0
//     blink                          : enable blinking of masked digits
//     blink_mask                     : bit i selects digit i for blinking
//   Display side (driven by the scanner, active low):
//     an  : anodes, an[i] drives digit i
//     seg : segments, seg[0]=a .. seg[6]=g
//     dp  : decimal point
//
//   master : digit source (drives digits/controls, observes display pins)
//   slave  : scanner (consumes digits/controls, drives display pins)
// ---------------------------------------------------------------------------
interface seven_seg_scan_if;
    logic [3:0] tenmin;
    logic [3:0] onemin;
    logic [3:0] tensec;
    logic [3:0] onesec;
    logic       lzb;
    logic       blink;
    logic [3:0] blink_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output tenmin, onemin, tensec, onesec,
        output lzb, blink, blink_mask,
        input  an, seg, dp
    );

    modport slave (
        input  tenmin, onemin, tensec, onesec,
        input  lzb, blink, blink_mask,
        output an, seg, dp
    );
endinterface

// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexes four BCD digits onto a 4-digit common-anode display.
//   The digits are snapshotted once per frame so a mid-frame input change
//   never tears the picture. Each digit slot starts with a short all-anodes-
//   off window (anti-ghosting); segment patterns only change inside it.
//   Digit 3 can be suppressed when zero, masked digits can blink, and
//   non-BCD values show a dash. The decimal point marks the mm.ss split and
//   is lit only while digit 2 is lit.
//
//   Parameters:
//     REFRESH_DIV  : clock cycles per digit slot
//     BLANK_CYCLES : dark cycles at the start of each slot
//                    (1 <= BLANK_CYCLES <= REFRESH_DIV-2)
//     BLINK_FRAMES : frames per blink half-period (>= 1)
//
//   Ports:
//     clk100MHz : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : seven_seg_scan_if.slave (digits, controls, an/seg/dp)
// ---------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic             clk100MHz,
    input  logic             rst_n,
    seven_seg_scan_if.slave  bus
);

    localparam int PW = (REFRESH_DIV  > 2) ? $clog2(REFRESH_DIV)  : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Digit slot currently being scanned (slot n drives an[n]).
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    slot_t            slot_q, slot_d;
    logic [PW-1:0]    pcnt_q;
    logic [FW-1:0]    fcnt_q;
    logic             bphase_q;
    logic [3:0][3:0]  snap_q;       // [3]=tenmin .. [0]=onesec
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             slot_end;
    logic             frame_end;
    logic             frame_wrap;

    logic [3:0]       digit;
    logic [3:0]       an_lit;
    logic             mask_sel;
    logic             lzb_sup;
    logic             blink_sup;
    logic             lit;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    // Active-high gfedcba pattern; anything outside 0-9 shows a dash.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    // -----------------------------------------------------------------------
    // Scan timing
    // -----------------------------------------------------------------------
    assign slot_end   = (pcnt_q == PCNT_LAST);
    assign frame_end  = slot_end && (slot_q == SLOT3);
    assign frame_wrap = frame_end && (fcnt_q == FCNT_LAST);

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (slot_end) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

    // Slot sequencer: state register
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Slot sequencer: next state, advances once per prescaler wrap
    always_comb begin
        slot_d = slot_q;
        if (slot_end) begin
            case (slot_q)
                SLOT0:   slot_d = SLOT1;
                SLOT1:   slot_d = SLOT2;
                SLOT2:   slot_d = SLOT3;
                SLOT3:   slot_d = SLOT0;
                default: slot_d = SLOT0;
            endcase
        end
    end

    // Snapshot, frame counter and blink phase all move on the 3->0 wrap.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (frame_end) begin
            snap_q <= {bus.tenmin, bus.onemin, bus.tensec, bus.onesec};
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q   <= '0;
            bphase_q <= 1'b0;
        end else if (frame_wrap) begin
            fcnt_q   <= '0;
            bphase_q <= ~bphase_q;
        end else if (frame_end) begin
            fcnt_q   <= fcnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (registered below, one cycle of latency)
    // -----------------------------------------------------------------------
    always_comb begin
        digit    = snap_q[0];
        an_lit   = 4'b1110;
        mask_sel = bus.blink_mask[0];
        case (slot_q)
            SLOT0: begin
                digit    = snap_q[0];
                an_lit   = 4'b1110;
                mask_sel = bus.blink_mask[0];
            end
            SLOT1: begin
                digit    = snap_q[1];
                an_lit   = 4'b1101;
                mask_sel = bus.blink_mask[1];
            end
            SLOT2: begin
                digit    = snap_q[2];
                an_lit   = 4'b1011;
                mask_sel = bus.blink_mask[2];
            end
            SLOT3: begin
                digit    = snap_q[3];
                an_lit   = 4'b0111;
                mask_sel = bus.blink_mask[3];
            end
            default: begin
                digit    = snap_q[0];
                an_lit   = 4'b1110;
                mask_sel = bus.blink_mask[0];
            end
        endcase
    end

    always_comb begin
        lzb_sup   = bus.lzb && (slot_q == SLOT3) && (snap_q[3] == 4'd0);
        blink_sup = bus.blink && mask_sel && bphase_q;
        lit       = (pcnt_q >= BLANK_END) && !lzb_sup && !blink_sup;

        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = an_lit;
            seg_d = ~glyph(digit);
            dp_d  = (slot_q != SLOT2);
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan
//   Self-checking bench for seven_seg_scan with REFRESH_DIV=8,
//   BLANK_CYCLES=2, BLINK_FRAMES=2. A time-based reference model derives
//   slot, digit, frame and blink phase from the cycle count since reset and
//   is compared against the DUT every cycle; directed tables and sequences
//   cover reset, scan order, anti-tear, glyphs, blink/LZB and async reset,
//   followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan;

    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned BF = 2;
    localparam int unsigned FRAME = 4 * RD;

    logic clk = 1'b0;
    logic rst_n;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seven_seg_scan_if bus ();

    seven_seg_scan #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk100MHz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0: g = 7'h3F;  4'd1: g = 7'h06;  4'd2: g = 7'h5B;
            4'd3: g = 7'h4F;  4'd4: g = 7'h66;  4'd5: g = 7'h6D;
            4'd6: g = 7'h7D;  4'd7: g = 7'h07;  4'd8: g = 7'h7F;
            4'd9: g = 7'h6F;  default: g = 7'h40;
        endcase
        return g;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: t = cycles since reset release. Outputs after an edge
    // reflect the slot/frame position held just before that edge.
    // -----------------------------------------------------------------------
    int unsigned t;
    logic [3:0]  m_snap [4];
    logic [3:0]  e_an  = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp  = 1'b1;

    always @(posedge clk or negedge rst_n) begin : model
        int unsigned p, f;
        logic [1:0]  d;
        logic        ph, lit;
        if (!rst_n) begin
            t <= 0;
            for (int i = 0; i < 4; i++) m_snap[i] <= 4'd0;
            e_an  <= 4'hF;
            e_seg <= 7'h7F;
            e_dp  <= 1'b1;
        end else begin
            p   = t % RD;
            d   = 2'((t / RD) % 4);
            f   = t / FRAME;
            ph  = ((f / BF) % 2) == 1;
            lit = (p >= BC)
                  && !(bus.lzb && d == 2'd3 && m_snap[3] == 4'd0)
                  && !(bus.blink && bus.blink_mask[d] && ph);
            e_an  <= lit ? ~(4'b0001 << d) : 4'hF;
            e_seg <= lit ? ~ref_glyph(m_snap[d]) : 7'h7F;
            e_dp  <= !(lit && d == 2'd2);
            if (p == RD - 1 && d == 2'd3) begin
                m_snap[3] <= bus.tenmin;
                m_snap[2] <= bus.onemin;
                m_snap[1] <= bus.tensec;
                m_snap[0] <= bus.onesec;
            end
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_an",  {3'b000, bus.an}, {3'b000, e_an});
            chk("model_seg", bus.seg, e_seg);
            chk("model_dp",  {6'b0, bus.dp}, {6'b0, e_dp});
        end
    end

    // Wait until the outputs show slot position (frame f, digit d, pcnt p).
    task automatic goto(input int unsigned f, input int unsigned d, input int unsigned p);
        int unsigned target;
        int unsigned n;
        target = f * FRAME + d * RD + p + 1;
        n = 0;
        while (t < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (t != target) begin
            errors++;
            $display("FAIL goto: cycle %0d required %0d", t, target);
        end
    endtask

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } scan_vec_t;

    typedef struct {
        logic [3:0] val;
        logic [6:0] seg;
    } glyph_vec_t;

    scan_vec_t  sv [4];
    glyph_vec_t gv [16];

    initial begin
        sv[0] = '{4'hE, 7'h19, 1'b1};
        sv[1] = '{4'hD, 7'h30, 1'b1};
        sv[2] = '{4'hB, 7'h24, 1'b0};
        sv[3] = '{4'h7, 7'h79, 1'b1};
        gv[0]  = '{4'd0,  7'h40};  gv[1]  = '{4'd1,  7'h79};
        gv[2]  = '{4'd2,  7'h24};  gv[3]  = '{4'd3,  7'h30};
        gv[4]  = '{4'd4,  7'h19};  gv[5]  = '{4'd5,  7'h12};
        gv[6]  = '{4'd6,  7'h02};  gv[7]  = '{4'd7,  7'h78};
        gv[8]  = '{4'd8,  7'h00};  gv[9]  = '{4'd9,  7'h10};
        gv[10] = '{4'd10, 7'h3F};  gv[11] = '{4'd11, 7'h3F};
        gv[12] = '{4'd12, 7'h3F};  gv[13] = '{4'd13, 7'h3F};
        gv[14] = '{4'd14, 7'h3F};  gv[15] = '{4'd15, 7'h3F};

        rst_n = 1'b1;
        bus.tenmin = 4'd1; bus.onemin = 4'd2; bus.tensec = 4'd3; bus.onesec = 4'd4;
        bus.lzb = 1'b0; bus.blink = 1'b0; bus.blink_mask = 4'b0000;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;

        // Reset hold
        repeat (3) @(negedge clk);
        chk("rst_an",  {3'b000, bus.an}, 7'h0F);
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_dp",  {6'b0, bus.dp}, 7'h01);
        rst_n = 1'b1;

        // Two blank cycles, then digit 0 from the all-zero reset snapshot
        goto(0, 0, 0); chk("post_rst_blank0", {3'b000, bus.an}, 7'h0F);
        goto(0, 0, 1); chk("post_rst_blank1", {3'b000, bus.an}, 7'h0F);
        goto(0, 0, 2); chk("first_lit_an", {3'b000, bus.an}, 7'h0E);
        chk("first_lit_seg", bus.seg, 7'h40);

        // Scan of 1,2,3,4 in frame 1
        for (int unsigned d = 0; d < 4; d++) begin
            goto(1, d, 1);
            chk("scan_blank_an", {3'b000, bus.an}, 7'h0F);
            goto(1, d, 2);
            chk("scan_an",  {3'b000, bus.an}, {3'b000, sv[d].an});
            chk("scan_seg", bus.seg, sv[d].seg);
            chk("scan_dp",  {6'b0, bus.dp}, {6'b0, sv[d].dp});
            goto(1, d, 7);
            chk("scan_last_an", {3'b000, bus.an}, {3'b000, sv[d].an});
        end

        // Anti-tear
        goto(2, 2, 3); bus.onesec = 4'd7;
        goto(3, 0, 3); chk("tear_new", bus.seg, 7'h78);
        bus.onesec = 4'd9;
        goto(3, 0, 6); chk("tear_hold", bus.seg, 7'h78);
        goto(4, 0, 4); chk("tear_next", bus.seg, 7'h10);

        // Glyph table, including invalid BCD
        for (int unsigned i = 0; i < 16; i++) begin
            goto(4 + i, 2, 3); bus.onesec = gv[i].val;
            goto(5 + i, 0, 4);
            chk("glyph_seg", bus.seg, gv[i].seg);
            chk("glyph_an",  {3'b000, bus.an}, 7'h0E);
            goto(5 + i, 1, 4);
            chk("glyph_other", bus.seg, 7'h30);
        end

        // Blink / leading-zero blanking
        goto(21, 2, 3);
        bus.blink = 1'b1; bus.blink_mask = 4'b0011; bus.lzb = 1'b1; bus.tenmin = 4'd0;
        for (int unsigned f = 22; f < 30; f++) begin
            logic dark;
            dark = ((f / BF) % 2) == 1;
            goto(f, 0, 4); chk("blink_d0", {3'b000, bus.an}, dark ? 7'h0F : 7'h0E);
            goto(f, 1, 4); chk("blink_d1", {3'b000, bus.an}, dark ? 7'h0F : 7'h0D);
            goto(f, 2, 4); chk("blink_d2", {3'b000, bus.an}, 7'h0B);
            goto(f, 3, 4); chk("lzb_d3",   {3'b000, bus.an}, 7'h0F);
        end
        goto(30, 3, 4); bus.blink = 1'b0;
        goto(31, 0, 4); chk("unblink_d0", {3'b000, bus.an}, 7'h0E);
        goto(31, 1, 4); chk("unblink_d1", {3'b000, bus.an}, 7'h0D);

        // Async reset during lit digit 2
        goto(32, 2, 4);
        chk("pre_arst_an", {3'b000, bus.an}, 7'h0B);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an",  {3'b000, bus.an}, 7'h0F);
        chk("arst_seg", bus.seg, 7'h7F);
        chk("arst_dp",  {6'b0, bus.dp}, 7'h01);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        goto(0, 0, 2);
        chk("restart_an",  {3'b000, bus.an}, 7'h0E);
        chk("restart_seg", bus.seg, 7'h40);

        // Randomized run against the model
        for (int unsigned c = 0; c < 40 * FRAME; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                bus.tenmin = 4'($urandom_range(0, 15));
                bus.onemin = 4'($urandom_range(0, 15));
                bus.tensec = 4'($urandom_range(0, 15));
                bus.onesec = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0) begin
                bus.lzb        = 1'($urandom_range(0, 1));
                bus.blink      = 1'($urandom_range(0, 1));
                bus.blink_mask = 4'($urandom_range(0, 15));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
